// File: rtl/uart_tx_fifo_sb_ctrl_if.sv
// Peripheral-bus register port of the UART transmitter: address, request,
// write strobe/data from the bus master, registered read data back.
interface uart_tx_fifo_sb_ctrl_if;
    logic [31:0] addr_i;
    logic        req_i;
    logic [31:0] write_data_i;
    logic        write_enable_i;
    logic [31:0] read_data_o;

    modport master (
        output addr_i, req_i, write_data_i, write_enable_i,
        input  read_data_o
    );

    modport slave (
        input  addr_i, req_i, write_data_i, write_enable_i,
        output read_data_o
    );
endinterface

// File: rtl/uart_tx_fifo_sb_ctrl.sv
// System-bus UART transmitter: register file, TX FIFO, baud divider and
// frame FSM (5-8 data bits, optional odd/even parity, 1 or 2 stop bits).
module uart_tx_fifo_sb_ctrl #(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned DEFAULT_BAUD = 9600,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    uart_tx_fifo_sb_ctrl_if.slave   bus,
    output logic                    tx_o
);
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W     = PTR_W + 1;
    localparam logic [16:0] DIV_RESET = 17'(CLK_FREQ / DEFAULT_BAUD);

    localparam logic [23:0] A_DATA   = 24'h00;
    localparam logic [23:0] A_STATUS = 24'h04;
    localparam logic [23:0] A_BUSY   = 24'h08;
    localparam logic [23:0] A_DIV    = 24'h0C;
    localparam logic [23:0] A_PAREN  = 24'h10;
    localparam logic [23:0] A_STOP   = 24'h14;
    localparam logic [23:0] A_PARODD = 24'h18;
    localparam logic [23:0] A_BITS   = 24'h1C;
    localparam logic [23:0] A_LEVEL  = 24'h20;
    localparam logic [23:0] A_SRST   = 24'h24;

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    // Register file and FIFO
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level;
    logic             overflow;
    logic [7:0]       last_byte;
    logic [16:0]      divisor;
    logic             par_en, stop2, par_odd;
    logic [1:0]       data_bits;

    // Frame FSM and the frame format latched at pop
    state_t           state;
    logic [16:0]      cnt;
    logic [7:0]       shift;
    logic [2:0]       bit_idx, nbits_m1;
    logic             f_par_en, f_par_bit, f_stop2, stop_idx;

    logic [23:0]      addr;
    logic [31:0]      wd, rdata;
    logic             wr, push, pop, soft_rst, cfg_wr;
    logic             empty, full, busy, frame_end, tx_next;
    logic [16:0]      div_m1;
    logic [7:0]       par_mask;
    logic             unused_bits;

    assign addr        = bus.addr_i[23:0];
    assign wd          = bus.write_data_i;
    assign unused_bits = ^{bus.addr_i[31:24], wd[31:17]};
    assign wr          = bus.req_i & bus.write_enable_i;
    assign empty       = (level == '0);
    assign full        = (level == LVL_W'(FIFO_DEPTH));
    assign busy        = (state != ST_IDLE) | ~empty;
    assign soft_rst    = wr && (addr == A_SRST);
    assign push        = wr && (addr == A_DATA) && !full;
    assign cfg_wr      = wr && !busy;
    assign div_m1      = divisor - 17'd1;
    // Last tick of the last stop bit: the FSM may chain straight into the next frame
    assign frame_end   = (state == ST_STOP) && (cnt == '0) && (stop_idx == f_stop2);
    assign pop         = !empty && ((state == ST_IDLE) || frame_end);
    // Only the configured number of low data bits contribute to parity
    assign par_mask    = 8'hFF >> (2'd3 - data_bits);

    // Line level driven during the current FSM state; registered into tx_o
    always_comb begin
        // NOTE: default first so every path assigns tx_next and no latch is inferred
        tx_next = 1'b1;
        case (state)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = shift[0];
            ST_PARITY: tx_next = f_par_bit;
            default:   tx_next = 1'b1;
        endcase
    end

    // Register read decode
    always_comb begin
        rdata = '0;
        case (addr)
            A_DATA:   rdata = {24'd0, last_byte};
            A_STATUS: rdata = {28'd0, overflow, empty, full, busy};
            A_BUSY:   rdata = {31'd0, busy};
            A_DIV:    rdata = {15'd0, divisor};
            A_PAREN:  rdata = {31'd0, par_en};
            A_STOP:   rdata = {31'd0, stop2};
            A_PARODD: rdata = {31'd0, par_odd};
            A_BITS:   rdata = {30'd0, data_bits};
            A_LEVEL:  rdata = 32'(level);
            default:  rdata = '0;
        endcase
    end

    // Registered read data: captured on every requested cycle, cleared only by rst_i
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: non-blocking assignments for all clocked state so every flop samples pre-edge values
        if (rst_i)          bus.read_data_o <= '0;
        else if (bus.req_i) bus.read_data_o <= rdata;
    end

    // FIFO storage, pointers, overflow flag and frame-format configuration
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || soft_rst) begin
            // NOTE: the FIFO array is cleared too, so a flush leaves no stale bytes behind
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            last_byte <= '0;
            divisor   <= DIV_RESET;
            par_en    <= 1'b1;
            stop2     <= 1'b1;
            par_odd   <= 1'b0;
            data_bits <= 2'd3;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= wd[7:0];
                wr_ptr           <= wr_ptr + 1'b1;
                last_byte        <= wd[7:0];
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (wr && (addr == A_DATA) && full) overflow <= 1'b1;
            else if (wr && (addr == A_STATUS))  overflow <= 1'b0;
            if (cfg_wr) begin
                case (addr)
                    A_DIV:    divisor   <= (wd[16:0] < 17'd2) ? 17'd2 : wd[16:0];
                    A_PAREN:  par_en    <= wd[0];
                    A_STOP:   stop2     <= wd[0];
                    A_PARODD: par_odd   <= wd[0];
                    A_BITS:   data_bits <= wd[1:0];
                    default:  ;
                endcase
            end
        end
    end

    // Frame FSM: each state lasts DIVISOR cycles via a down-counter reloaded on entry
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || soft_rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            shift     <= '0;
            bit_idx   <= '0;
            nbits_m1  <= '0;
            f_par_en  <= 1'b0;
            f_par_bit <= 1'b0;
            f_stop2   <= 1'b0;
            stop_idx  <= 1'b0;
            tx_o      <= 1'b1;
        end else begin
            tx_o <= tx_next;
            case (state)
                ST_IDLE: ;
                ST_START: begin
                    if (cnt == '0) begin
                        state   <= ST_DATA;
                        cnt     <= div_m1;
                        bit_idx <= '0;
                    end else cnt <= cnt - 1'b1;
                end
                ST_DATA: begin
                    if (cnt == '0) begin
                        shift <= shift >> 1;
                        cnt   <= div_m1;
                        if (bit_idx == nbits_m1) begin
                            state    <= f_par_en ? ST_PARITY : ST_STOP;
                            stop_idx <= 1'b0;
                        end else bit_idx <= bit_idx + 1'b1;
                    end else cnt <= cnt - 1'b1;
                end
                ST_PARITY: begin
                    if (cnt == '0) begin
                        state    <= ST_STOP;
                        cnt      <= div_m1;
                        stop_idx <= 1'b0;
                    end else cnt <= cnt - 1'b1;
                end
                ST_STOP: begin
                    if (cnt == '0) begin
                        if (stop_idx != f_stop2) begin
                            stop_idx <= 1'b1;
                            cnt      <= div_m1;
                        end else state <= ST_IDLE;
                    end else cnt <= cnt - 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
            // A pop starts the next frame and overrides the IDLE return above
            if (pop) begin
                state     <= ST_START;
                cnt       <= div_m1;
                shift     <= fifo_mem[rd_ptr];
                nbits_m1  <= 3'd4 + {1'b0, data_bits};
                f_par_en  <= par_en;
                f_par_bit <= (^(fifo_mem[rd_ptr] & par_mask)) ^ par_odd;
                f_stop2   <= stop2;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo_sb_ctrl.sv
// Self-checking bench for uart_tx_fifo_sb_ctrl: directed register/boundary
// checks plus randomized frames compared against a wire-level frame model.
module tb_uart_tx_fifo_sb_ctrl;
    localparam int unsigned CLK_FREQ   = 50_000_000;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned DIV_RST    = CLK_FREQ / 9600;

    localparam logic [31:0] A_DATA   = 32'h00;
    localparam logic [31:0] A_STATUS = 32'h04;
    localparam logic [31:0] A_BUSY   = 32'h08;
    localparam logic [31:0] A_DIV    = 32'h0C;
    localparam logic [31:0] A_PAREN  = 32'h10;
    localparam logic [31:0] A_STOP   = 32'h14;
    localparam logic [31:0] A_PARODD = 32'h18;
    localparam logic [31:0] A_BITS   = 32'h1C;
    localparam logic [31:0] A_LEVEL  = 32'h20;
    localparam logic [31:0] A_SRST   = 32'h24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;
    uart_tx_fifo_sb_ctrl_if bus ();

    uart_tx_fifo_sb_ctrl #(
        .CLK_FREQ(CLK_FREQ), .DEFAULT_BAUD(9600), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus), .tx_o(tx)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: frame format and queue of bytes expected on the wire
    int unsigned m_div, m_bits, m_par_en, m_odd, m_stop2;
    logic [7:0]  exp_q[$];

    function automatic void model_defaults();
        m_div = DIV_RST; m_bits = 8; m_par_en = 1; m_odd = 0; m_stop2 = 1;
    endfunction

    function automatic int unsigned frame_len();
        return 1 + m_bits + m_par_en + 1 + m_stop2;
    endfunction

    // Bit i of the result is the i-th bit period on the line (start first)
    function automatic logic [11:0] frame_vec(input logic [7:0] d);
        logic [11:0] v;
        int unsigned ones;
        v = '1;
        v[0] = 1'b0;
        ones = 0;
        for (int i = 0; i < int'(m_bits); i++) begin
            v[1 + i] = d[i];
            ones += int'(d[i]);
        end
        if (m_par_en != 0) v[1 + m_bits] = ((ones % 2) == 1) ^ (m_odd != 0);
        return v;
    endfunction

    // Line monitor: detects a start bit and records every bit period of the frame
    typedef struct {
        logic [11:0] bits;
        logic        stable;
        int unsigned start_cyc;
    } rx_t;
    rx_t         rx_q[$];
    logic        mon_en = 1'b0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin : monitor
        rx_t f;
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                f.bits = '1;
                f.stable = 1'b1;
                f.start_cyc = cyc;
                for (int b = 0; b < int'(frame_len()); b++) begin
                    for (int c = 0; c < int'(m_div); c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (c == 0) f.bits[b] = tx;
                        else if (tx !== f.bits[b]) f.stable = 1'b0;
                    end
                end
                rx_q.push_back(f);
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Bus tasks: start and end just after a falling edge, one rising edge per access
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.addr_i = a; bus.write_data_i = d; bus.req_i = 1'b1; bus.write_enable_i = 1'b1;
        @(negedge clk);
        bus.req_i = 1'b0; bus.write_enable_i = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus.addr_i = a; bus.req_i = 1'b1; bus.write_enable_i = 1'b0;
        @(negedge clk);
        d = bus.read_data_o;
        bus.req_i = 1'b0;
    endtask

    task automatic push_byte(input logic [31:0] d);
        bus_write(A_DATA, d);
        exp_q.push_back(d[7:0]);
    endtask

    task automatic set_cfg(input int unsigned div, input int unsigned bits_code,
                           input int unsigned pe, input int unsigned odd, input int unsigned st2);
        bus_write(A_DIV, div);
        bus_write(A_PAREN, pe);
        bus_write(A_STOP, st2);
        bus_write(A_PARODD, odd);
        bus_write(A_BITS, bits_code);
        m_div = (div < 2) ? 2 : div;
        m_bits = 5 + bits_code; m_par_en = pe; m_odd = odd; m_stop2 = st2;
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] v;
        int unsigned n;
        n = 0;
        do begin
            bus_read(A_BUSY, v);
            n++;
        end while (v[0] && n < 3000);
        check({tag, "_idle_timeout"}, v, 32'h0);
        repeat (3) @(negedge clk);
    endtask

    task automatic expect_frames(input string tag);
        rx_t         r;
        logic [7:0]  e;
        check({tag, "_frame_count"}, rx_q.size(), exp_q.size());
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            r = rx_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_frame_bits"}, 32'(r.bits), 32'(frame_vec(e)));
            check({tag, "_bit_stable"}, 32'(r.stable), 32'h1);
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin : main
        logic [31:0] v, d;
        logic [11:0] fv;
        rx_t         r0, r1;
        int unsigned nb;
        bus.addr_i = '0; bus.req_i = 1'b0; bus.write_data_i = '0; bus.write_enable_i = 1'b0;
        model_defaults();

        // 1: reset state
        repeat (3) @(negedge clk);
        check("rst_tx_held", 32'(tx), 32'h1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_rdata", bus.read_data_o, 32'h0);
        bus_read(A_STATUS, v); check("rst_status", v, 32'h4);
        bus_read(A_DIV, v);    check("rst_divisor", v, DIV_RST);
        bus_read(A_BITS, v);   check("rst_data_bits", v, 32'h3);
        bus_read(A_LEVEL, v);  check("rst_level", v, 32'h0);
        bus_read(A_PAREN, v);  check("rst_parity_en", v, 32'h1);
        bus_read(A_STOP, v);   check("rst_stopbit", v, 32'h1);
        bus_read(32'h40, v);   check("unmapped_read", v, 32'h0);
        bus_read(32'h0100_001C, v); check("addr_upper_ignored", v, 32'h3);
        check("rst_tx", 32'(tx), 32'h1);

        // Divisor clamp boundary
        bus_write(A_DIV, 32'd1); bus_read(A_DIV, v); check("div_clamp_1", v, 32'd2);
        bus_write(A_DIV, 32'd0); bus_read(A_DIV, v); check("div_clamp_0", v, 32'd2);

        // 2: exact waveform of 0xA5 with DIVISOR=4 and default format
        bus_write(A_DIV, 32'd4); m_div = 4;
        bus_write(A_DATA, 32'hA5);
        fv = frame_vec(8'hA5);
        @(negedge clk);
        check("t2_idle_before_start", 32'(tx), 32'h1);
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            check($sformatf("t2_bit%0d", k / 4), 32'(tx), 32'(fv[k / 4]));
        end
        bus_read(A_BUSY, v); check("t2_busy_done", v, 32'h0);
        bus_read(A_DATA, v); check("t2_last_byte", v, 32'hA5);

        // 3: 5 data bits, no parity, 1 stop, back-to-back frames without a gap
        set_cfg(2, 0, 0, 0, 0);
        mon_en = 1'b1;
        push_byte(32'h1F);
        push_byte(32'h00);
        wait_idle("t3");
        if (rx_q.size() == 2) begin
            r0 = rx_q[0]; r1 = rx_q[1];
            check("t3_no_gap", r1.start_cyc - r0.start_cyc, 32'd14);
        end
        expect_frames("t3");

        // 4: overflow while transmitting; first FIFO_DEPTH+1 bytes go out
        set_cfg(2, 3, 0, 0, 0);
        for (int i = 0; i < int'(FIFO_DEPTH) + 2; i++) begin
            d = $urandom;
            bus_write(A_DATA, d);
            if (i < int'(FIFO_DEPTH) + 1) exp_q.push_back(d[7:0]);
        end
        bus_read(A_STATUS, v); check("t4_status_full_ovf", v, 32'hB);
        bus_read(A_LEVEL, v);  check("t4_level_full", v, FIFO_DEPTH);
        wait_idle("t4");
        expect_frames("t4");
        bus_read(A_STATUS, v); check("t4_ovf_sticky", v, 32'hC);
        bus_write(A_STATUS, 32'h0);
        bus_read(A_STATUS, v); check("t4_ovf_cleared", v, 32'h4);

        // 5: config write while busy is ignored; odd parity
        set_cfg(3, 3, 1, 0, 0);
        push_byte(32'h5A);
        bus_write(A_DIV, 32'd7);
        bus_read(A_DIV, v); check("t5_div_locked", v, 32'd3);
        wait_idle("t5a");
        expect_frames("t5a");
        set_cfg(3, 3, 1, 1, 0);
        push_byte(32'h03);
        wait_idle("t5b");
        if (rx_q.size() > 0) begin
            r0 = rx_q[0];
            check("t5_odd_parity_bit", 32'(r0.bits[9]), 32'h1);
        end
        expect_frames("t5b");

        // Randomized frames and formats
        for (int round = 0; round < 8; round++) begin
            set_cfg($urandom_range(4, 2), $urandom_range(3, 0), $urandom_range(1, 0),
                    $urandom_range(1, 0), $urandom_range(1, 0));
            nb = $urandom_range(5, 1);
            for (int i = 0; i < int'(nb); i++) begin
                d = $urandom;
                push_byte(d);
                repeat ($urandom_range(30, 0)) @(negedge clk);
            end
            bus_read(A_DATA, v); check($sformatf("rnd%0d_last_byte", round), v, 32'(d[7:0]));
            wait_idle($sformatf("rnd%0d", round));
            expect_frames($sformatf("rnd%0d", round));
        end

        // 6a: soft reset in the middle of the data bits
        mon_en = 1'b0;
        set_cfg(4, 3, 1, 1, 0);
        bus_write(A_DATA, 32'h00);
        bus_write(A_DATA, 32'h00);
        bus_write(A_DATA, 32'h00);
        repeat (6) @(negedge clk);
        check("t6_in_data_low", 32'(tx), 32'h0);
        bus_write(A_SRST, 32'h1);
        check("t6_soft_tx_high", 32'(tx), 32'h1);
        model_defaults();
        bus_read(A_LEVEL, v);  check("t6_soft_level", v, 32'h0);
        bus_read(A_STATUS, v); check("t6_soft_status", v, 32'h4);
        bus_read(A_DIV, v);    check("t6_soft_divisor", v, DIV_RST);
        bus_read(A_PARODD, v); check("t6_soft_parodd", v, 32'h0);
        bus_read(A_DATA, v);   check("t6_soft_last_byte", v, 32'h0);
        check("t6_soft_tx_stays", 32'(tx), 32'h1);

        // 6b: asynchronous reset mid-frame acts without a clock edge
        set_cfg(4, 3, 1, 0, 1);
        bus_write(A_DATA, 32'h00);
        repeat (6) @(negedge clk);
        bus_read(A_DIV, v); check("t6_pre_rst_rdata", v, 32'd4);
        check("t6_pre_rst_tx_low", 32'(tx), 32'h0);
        #2 rst = 1'b1;
        #1;
        check("t6_async_tx", 32'(tx), 32'h1);
        check("t6_async_rdata", bus.read_data_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_defaults();
        @(negedge clk);
        bus_read(A_STATUS, v); check("t6_post_rst_status", v, 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
